// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter: requester identity and the hard-wired zero register.
package wb_pkg;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LD  = 1'b1
  } wb_src_e;

  localparam int unsigned REG_X0 = 0;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between the ALU and load-return writeback requesters.
module rr_arbiter2
  import wb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_alu_i,
  input  logic req_ld_i,
  output logic gnt_alu_o,
  output logic gnt_ld_o
);

  wb_src_e last_q, last_d;

  // Grants are gated by reset so requesters held valid through reset see ready low.
  always_comb begin
    gnt_alu_o = ~rst & req_alu_i & (~req_ld_i | (last_q == SRC_LD));
    gnt_ld_o  = ~rst & req_ld_i  & (~req_alu_i | (last_q == SRC_ALU));
    last_d    = last_q;
    if (gnt_alu_o) begin
      last_d = SRC_ALU;
    end else if (gnt_ld_o) begin
      last_d = SRC_LD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= SRC_LD;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU and load-return writebacks, registers the granted
// write for one cycle, and tracks outstanding loads to raise a read-hazard stall.
module regfile_wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned REGWIDTH  = 5,
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [REGWIDTH-1:0]  alu_rd,
  input  logic [DATAWIDTH-1:0] alu_data,
  output logic                 alu_ready,
  input  logic                 ld_issue,
  input  logic [REGWIDTH-1:0]  ld_issue_rd,
  input  logic                 ld_valid,
  input  logic [REGWIDTH-1:0]  ld_rd,
  input  logic [DATAWIDTH-1:0] ld_data,
  output logic                 ld_ready,
  input  logic [REGWIDTH-1:0]  rs1,
  input  logic [REGWIDTH-1:0]  rs2,
  output logic                 stall,
  output logic                 RegWrite,
  output logic [REGWIDTH-1:0]  rd_out,
  output logic [DATAWIDTH-1:0] writeData
);

  localparam int unsigned NREGS = 1 << REGWIDTH;
  localparam logic [REGWIDTH-1:0] X0 = REGWIDTH'(REG_X0);

  logic                 we_q, we_d;
  logic [REGWIDTH-1:0]  rd_q, rd_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  wb_src_e              src_q, src_d;
  logic [NREGS-1:0]     busy_q, busy_d;
  logic                 hz1, hz2;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_alu_i (alu_valid),
    .req_ld_i  (ld_valid),
    .gnt_alu_o (alu_ready),
    .gnt_ld_o  (ld_ready)
  );

  always_comb begin
    we_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    src_d  = src_q;
    if (alu_ready) begin
      we_d   = (alu_rd != X0);
      rd_d   = alu_rd;
      data_d = alu_data;
      src_d  = SRC_ALU;
    end else if (ld_ready) begin
      we_d   = (ld_rd != X0);
      rd_d   = ld_rd;
      data_d = ld_data;
      src_d  = SRC_LD;
    end
  end

  // Clear before set so a new reservation issued while the old load retires survives.
  always_comb begin
    busy_d = busy_q;
    if (we_q && (src_q == SRC_LD)) begin
      busy_d[rd_q] = 1'b0;
    end
    if (ld_issue && (ld_issue_rd != X0)) begin
      busy_d[ld_issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      src_q  <= SRC_ALU;
      busy_q <= '0;
    end else begin
      we_q   <= we_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      src_q  <= src_d;
      busy_q <= busy_d;
    end
  end

  // Masking with rst stops a write captured just before reset from reaching the regfile.
  assign RegWrite  = we_q & ~rst;
  assign rd_out    = rd_q;
  assign writeData = data_q;

  assign hz1   = (rs1 != X0) && (busy_q[rs1] || (RegWrite && (rd_q == rs1)));
  assign hz2   = (rs2 != X0) && (busy_q[rs2] || (RegWrite && (rd_q == rs2)));
  assign stall = hz1 | hz2;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, ld_issue, ld_valid, ld_ready, stall, RegWrite;
  logic [4:0]  alu_rd, ld_issue_rd, ld_rd, rs1, rs2, rd_out;
  logic [31:0] alu_data, ld_data, writeData;

  int checks = 0;
  int failures = 0;

  // Reference model: winner pointer, reservation set, and the write expected on the port this cycle.
  int          m_last;
  bit [31:0]   m_busy;
  bit          m_we;
  int          m_rd;
  logic [31:0] m_data;
  int          m_src;

  regfile_wb_arbiter #(.REGWIDTH(5), .DATAWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rs1(rs1), .rs2(rs2), .stall(stall),
    .RegWrite(RegWrite), .rd_out(rd_out), .writeData(writeData)
  );

  always #5 clk = ~clk;

  // 0 = ALU, 1 = LD, -1 = nobody granted.
  function automatic int winner();
    if (rst) return -1;
    if (alu_valid && ld_valid) return (m_last == 1) ? 0 : 1;
    if (alu_valid) return 0;
    if (ld_valid) return 1;
    return -1;
  endfunction

  function automatic bit exp_regwrite();
    return m_we && !rst;
  endfunction

  function automatic bit reads_stale(input int rs);
    if (rs == 0) return 1'b0;
    return m_busy[rs] || (exp_regwrite() && (m_rd == rs));
  endfunction

  function automatic bit exp_stall();
    return reads_stale(int'(rs1)) || reads_stale(int'(rs2));
  endfunction

  task automatic model_reset();
    m_last = 1; m_busy = '0; m_we = 0; m_rd = 0; m_data = '0; m_src = 0;
  endtask

  task automatic tick();
    int w;
    bit r, iss;
    int iss_rd, ard, lrd;
    logic [31:0] ad, ldd;
    w = winner(); r = rst; iss = ld_issue; iss_rd = int'(ld_issue_rd);
    ard = int'(alu_rd); lrd = int'(ld_rd); ad = alu_data; ldd = ld_data;
    if (!r && iss && iss_rd != 0)
      assert (!m_busy[iss_rd]) else $error("illegal load issue to reserved register x%0d", iss_rd);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (m_we && m_src == 1) m_busy[m_rd] = 1'b0;
      if (iss && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      m_we = 0;
      if (w == 0) begin
        m_we = (ard != 0); m_rd = ard; m_data = ad; m_src = 0; m_last = 0;
      end else if (w == 1) begin
        m_we = (lrd != 0); m_rd = lrd; m_data = ldd; m_src = 1; m_last = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    ld_issue = 0; ld_issue_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
      ld_valid = 1'($urandom); ld_rd = 5'($urandom); ld_data = $urandom;
      ld_issue = 1'($urandom); ld_issue_rd = 5'($urandom);
      rs1 = 5'($urandom); rs2 = 5'($urandom);
      alu_valid = 1; ld_valid = 1;
      #2;
      checks++; if (alu_ready !== 1'b0) begin failures++; $display("FAIL reset_alu_ready got=%b exp=0", alu_ready); end
      checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL reset_ld_ready got=%b exp=0", ld_ready); end
      tick();
    end
    rst = 0;
    alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
    ld_valid = 0; ld_issue = 0; rs1 = 5'($urandom); rs2 = 5'($urandom);
    #2;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL post_reset_regwrite got=%b exp=0", RegWrite); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL post_reset_stall got=%b exp=0", stall); end
    checks++; if (alu_ready !== alu_valid) begin failures++; $display("FAIL post_reset_alu_ready got=%b exp=%b", alu_ready, alu_valid); end
    tick();
    idle(); tick();
  endtask

  task automatic test_alu_only();
    idle();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
    #2;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL alu_only_ready got=%b exp=1", alu_ready); end
    tick();
    alu_valid = 0;
    #2;
    checks++; if (RegWrite !== 1'b1) begin failures++; $display("FAIL alu_only_we got=%b exp=1", RegWrite); end
    checks++; if (rd_out !== 5'd5) begin failures++; $display("FAIL alu_only_rd got=%0d exp=5", rd_out); end
    checks++; if (writeData !== 32'h1234) begin failures++; $display("FAIL alu_only_data got=%h exp=00001234", writeData); end
    tick();
  endtask

  task automatic test_contention();
    int ai, li;
    logic [4:0]  prev_rd;
    logic [31:0] prev_data;
    do_reset();
    ai = 0; li = 0; prev_rd = '0; prev_data = '0;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1; alu_rd = 5'(10 + ai); alu_data = 32'hA000 + ai;
      ld_valid = 1; ld_rd = 5'(20 + li); ld_data = 32'hB000 + li;
      #2;
      checks++; if (alu_ready !== ((i % 2) == 0)) begin failures++; $display("FAIL cont_alu_grant%0d got=%b exp=%b", i, alu_ready, (i % 2) == 0); end
      checks++; if (ld_ready !== ((i % 2) == 1)) begin failures++; $display("FAIL cont_ld_grant%0d got=%b exp=%b", i, ld_ready, (i % 2) == 1); end
      if (i > 0) begin
        checks++; if (RegWrite !== 1'b1 || rd_out !== prev_rd || writeData !== prev_data) begin
          failures++; $display("FAIL cont_write%0d got=%b/%0d/%h exp=1/%0d/%h", i - 1, RegWrite, rd_out, writeData, prev_rd, prev_data);
        end
      end
      if ((i % 2) == 0) begin prev_rd = alu_rd; prev_data = alu_data; ai++; end
      else begin prev_rd = ld_rd; prev_data = ld_data; li++; end
      tick();
    end
    idle();
    #2;
    checks++; if (RegWrite !== 1'b1 || rd_out !== prev_rd || writeData !== prev_data) begin
      failures++; $display("FAIL cont_write3 got=%b/%0d/%h exp=1/%0d/%h", RegWrite, rd_out, writeData, prev_rd, prev_data);
    end
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    ld_issue = 1; ld_issue_rd = 5'd7;
    #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_pre_issue_stall got=%b exp=0", stall); end
    tick();
    ld_issue = 0; rs1 = 5'd7;
    #2;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_busy_stall got=%b exp=1", stall); end
    tick();
    ld_valid = 1; ld_rd = 5'd7; ld_data = 32'hCAFE;
    #2;
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL sb_ld_ready got=%b exp=1", ld_ready); end
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_stall_N got=%b exp=1", stall); end
    tick();
    ld_valid = 0;
    #2;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_stall_N1 got=%b exp=1", stall); end
    checks++; if (RegWrite !== 1'b1 || rd_out !== 5'd7 || writeData !== 32'hCAFE) begin
      failures++; $display("FAIL sb_write got=%b/%0d/%h exp=1/7/0000cafe", RegWrite, rd_out, writeData);
    end
    tick();
    #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_stall_N2 got=%b exp=0", stall); end
    rs1 = 5'd0; rs2 = 5'd7;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_busy7_clear got=%b exp=0", stall); end
    rs2 = 5'd0;
    ld_valid = 1; ld_rd = 5'd8; ld_data = 32'hBEEF;
    tick();
    ld_valid = 0; ld_issue = 1; ld_issue_rd = 5'd8; rs1 = 5'd8;
    tick();
    ld_issue = 0;
    #2;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sb_set_wins got=%b exp=1", stall); end
    ld_valid = 1; ld_rd = 5'd8; ld_data = 32'h8;
    tick();
    ld_valid = 0;
    tick();
    #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_busy8_clear got=%b exp=0", stall); end
    idle(); tick();
  endtask

  task automatic test_x0();
    idle();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h55;
    #2;
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL x0_alu_ready got=%b exp=1", alu_ready); end
    tick();
    alu_valid = 0; ld_issue = 1; ld_issue_rd = 5'd0;
    #2;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL x0_no_write got=%b exp=0", RegWrite); end
    tick();
    ld_issue = 0; rs1 = 5'd0; rs2 = 5'd0;
    #2;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL x0_stall got=%b exp=0", stall); end
    alu_valid = 1; alu_rd = 5'd0; ld_valid = 1; ld_rd = 5'd0;
    #1;
    checks++; if (ld_ready !== 1'b1 || alu_ready !== 1'b0) begin
      failures++; $display("FAIL x0_last_updated got=alu%b/ld%b exp=alu0/ld1", alu_ready, ld_ready);
    end
    tick();
    ld_valid = 0;
    #2;
    checks++; if (alu_ready !== 1'b1 || RegWrite !== 1'b0) begin
      failures++; $display("FAIL x0_second got=ready%b/we%b exp=ready1/we0", alu_ready, RegWrite);
    end
    tick();
    idle(); tick();
  endtask

  task automatic test_reset_midop();
    idle();
    ld_issue = 1; ld_issue_rd = 5'd9;
    tick();
    ld_issue = 0; ld_valid = 1; ld_rd = 5'd3; ld_data = 32'h333;
    #2;
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL midrst_ld_ready got=%b exp=1", ld_ready); end
    tick();
    ld_valid = 0; rst = 1;
    #2;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL midrst_suppress got=%b exp=0", RegWrite); end
    tick();
    rst = 0; rs1 = 5'd9;
    #2;
    checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL midrst_after_we got=%b exp=0", RegWrite); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL midrst_stall got=%b exp=0", stall); end
    idle(); tick();
  endtask

  task automatic test_random();
    bit alu_hold, ld_hold;
    int w, r;
    alu_hold = 0; ld_hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (!alu_hold) begin alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom; end
      if (!ld_hold) begin ld_valid = 1'($urandom); ld_rd = 5'($urandom); ld_data = $urandom; end
      ld_issue = 0;
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 31);
        if (r == 0 || !m_busy[r]) begin ld_issue = 1; ld_issue_rd = 5'(r); end
      end
      rs1 = ($urandom_range(0, 2) == 0) ? 5'(m_rd) : 5'($urandom);
      rs2 = 5'($urandom);
      rst = ($urandom_range(0, 79) == 0);
      #2;
      w = winner();
      checks++; if (alu_ready !== (w == 0)) begin failures++; $display("FAIL rnd_alu_ready c=%0d got=%b exp=%b", c, alu_ready, w == 0); end
      checks++; if (ld_ready !== (w == 1)) begin failures++; $display("FAIL rnd_ld_ready c=%0d got=%b exp=%b", c, ld_ready, w == 1); end
      checks++; if (stall !== exp_stall()) begin failures++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, exp_stall()); end
      checks++; if (RegWrite !== exp_regwrite()) begin failures++; $display("FAIL rnd_regwrite c=%0d got=%b exp=%b", c, RegWrite, exp_regwrite()); end
      if (exp_regwrite()) begin
        checks++; if (rd_out !== 5'(m_rd) || writeData !== m_data) begin
          failures++; $display("FAIL rnd_write c=%0d got=%0d/%h exp=%0d/%h", c, rd_out, writeData, m_rd, m_data);
        end
      end
      alu_hold = alu_valid && (w != 0);
      ld_hold  = ld_valid && (w != 1);
      tick();
    end
    rst = 0; idle(); tick();
  endtask

  initial begin
    rst = 1;
    idle();
    model_reset();
    test_reset();
    test_alu_only();
    test_contention();
    test_scoreboard();
    test_x0();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
